// File: rtl/prog_mem_if.sv
// prog_mem bus: read port (pc -> instr) and bit-serial loader port.
// master = controller side, slave = program memory side.
interface prog_mem_if #(
  parameter int IW = 3,
  parameter int AW = 3
);
  logic [AW-1:0] i_pc;
  logic [IW-1:0] o_instr;
  logic          i_ld_start;
  logic          i_ld_valid;
  logic          i_ld_bit;
  logic          o_ld_busy;
  logic          o_ld_done;
  logic          o_ld_err;

  modport master (
    output i_pc,
    output i_ld_start,
    output i_ld_valid,
    output i_ld_bit,
    input  o_instr,
    input  o_ld_busy,
    input  o_ld_done,
    input  o_ld_err
  );

  modport slave (
    input  i_pc,
    input  i_ld_start,
    input  i_ld_valid,
    input  i_ld_bit,
    output o_instr,
    output o_ld_busy,
    output o_ld_done,
    output o_ld_err
  );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: program memory with reset-default program and serial reloader.
// Ports: i_clk, i_rst (sync, active-high), bus (prog_mem_if.slave):
//   i_pc/o_instr read port; i_ld_start/i_ld_valid/i_ld_bit load input;
//   o_ld_busy/o_ld_done/o_ld_err loader status.
module prog_mem #(
  parameter int IW      = 3,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int REG_OUT = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  prog_mem_if.slave  bus
);

  localparam int CW = $clog2(IW + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  function automatic logic [IW-1:0] f_default(input int idx);
    logic [IW-1:0] v;
    unique case (idx)
      1:       v = IW'(3'd7);
      2:       v = IW'(3'd1);
      3:       v = IW'(3'd2);
      4:       v = IW'(3'd1);
      5:       v = IW'(3'd3);
      6:       v = IW'(3'd4);
      7:       v = IW'(3'd6);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [IW-1:0] r_mem [DEPTH];

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_bit_cnt;
  logic [IW-2:0] r_shreg;
  logic          r_done;
  logic          r_err;

  state_t        w_state_nxt;
  logic [AW-1:0] w_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [IW-2:0] w_sh_nxt;
  logic          w_done_nxt;
  logic          w_err_nxt;
  logic          w_we;
  logic [IW-1:0] w_wdata;

  assign w_wdata = {r_shreg, bus.i_ld_bit};

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_wr_ptr;
    w_cnt_nxt   = r_bit_cnt;
    w_sh_nxt    = r_shreg;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_ld_start) begin
          w_state_nxt = S_LOAD;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        // A restart wins over a same-cycle valid bit, which is dropped.
        if (bus.i_ld_start) begin
          w_ptr_nxt = '0;
          w_cnt_nxt = '0;
          w_err_nxt = 1'b1;
        end else if (bus.i_ld_valid) begin
          w_sh_nxt = {r_shreg[IW-3:0], bus.i_ld_bit};
          if (r_bit_cnt == CW'(IW - 1)) begin
            w_we      = 1'b1;
            w_cnt_nxt = '0;
            w_ptr_nxt = r_wr_ptr + AW'(1);
            if (r_wr_ptr == AW'(DEPTH - 1)) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_ptr_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shreg   <= w_sh_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= f_default(i);
      end
    end else if (w_we) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [IW-1:0] r_instr;
      // Samples the pre-edge word, so a same-address write shows next cycle.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_instr <= '0;
        end else begin
          r_instr <= r_mem[bus.i_pc];
        end
      end
      assign bus.o_instr = r_instr;
    end else begin : g_comb
      assign bus.o_instr = r_mem[bus.i_pc];
    end
  endgenerate

  assign bus.o_ld_busy = (r_state == S_LOAD);
  assign bus.o_ld_done = r_done;
  assign bus.o_ld_err  = r_err;

endmodule
